// File: rtl/servo_pkg.sv
// Shared servo constants and the angle type used by the ramp sequencer
// and the angle-to-pulse-width converters.
package servo_pkg;
   localparam int ANGLE_W          = 8;
   localparam int MAX_ANGLE        = 180;
   localparam int HOME_ANGLE       = 90;
   localparam int FRAME_CYCLES_50M = 1000000;

   typedef logic [ANGLE_W-1:0] angle_t;
endpackage

// File: rtl/servo_joint_ramp.sv
// One joint: holds target and current angle and moves current toward target
// by at most STEP degrees on each frame step.
//   state     | meaning
//   AT_TARGET | current == target, o_at_target = 1, angle holds
//   RAMPING   | current != target, o_at_target = 0, steps on each i_step
module servo_joint_ramp
   import servo_pkg::*;
#(
   parameter int STEP       = 2,
   parameter int HOME_ANGLE = servo_pkg::HOME_ANGLE,
   parameter int MAX_ANGLE  = servo_pkg::MAX_ANGLE
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       i_load,
   input  logic [7:0] i_angle,
   input  logic       i_step,
   output logic [7:0] o_angle,
   output logic       o_at_target,
   output logic       o_at_target_nxt
);
   angle_t     r_cur;
   angle_t     r_tgt;
   logic       r_at_target;
   angle_t     w_cur_nxt;
   angle_t     w_tgt_nxt;
   logic [8:0] w_diff;

   always_comb begin
      w_cur_nxt = r_cur;
      w_diff    = '0;
      // The step always uses the target held before this edge, so a command
      // landing on a frame edge only takes effect on the following frame.
      if (i_step) begin
         if (r_cur < r_tgt) begin
            w_diff    = {1'b0, r_tgt} - {1'b0, r_cur};
            w_cur_nxt = (w_diff <= 9'(STEP)) ? r_tgt : r_cur + angle_t'(STEP);
         end else if (r_cur > r_tgt) begin
            w_diff    = {1'b0, r_cur} - {1'b0, r_tgt};
            w_cur_nxt = (w_diff <= 9'(STEP)) ? r_tgt : r_cur - angle_t'(STEP);
         end
      end
      w_tgt_nxt = r_tgt;
      if (i_load) begin
         w_tgt_nxt = (i_angle > angle_t'(MAX_ANGLE)) ? angle_t'(MAX_ANGLE) : i_angle;
      end
      o_at_target_nxt = (w_cur_nxt == w_tgt_nxt);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cur       <= angle_t'(HOME_ANGLE);
         r_tgt       <= angle_t'(HOME_ANGLE);
         r_at_target <= 1'b1;
      end else begin
         r_cur       <= w_cur_nxt;
         r_tgt       <= w_tgt_nxt;
         r_at_target <= o_at_target_nxt;
      end
   end

   assign o_angle     = r_cur;
   assign o_at_target = r_at_target;
endmodule

// File: rtl/servo_ramp_sequencer.sv
// Robot-arm joint sequencer: frame counter, command decode and per-joint
// ramp instances packed onto a shared angle bus.
module servo_ramp_sequencer
   import servo_pkg::*;
#(
   parameter int NJ           = 4,
   parameter int FRAME_CYCLES = servo_pkg::FRAME_CYCLES_50M,
   parameter int CNT_W        = 20,
   parameter int STEP         = 2,
   parameter int HOME_ANGLE   = servo_pkg::HOME_ANGLE,
   parameter int MAX_ANGLE    = servo_pkg::MAX_ANGLE
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [2:0]      cmd_joint,
   input  logic [7:0]      cmd_angle,
   output logic [NJ*8-1:0] angle_bus,
   output logic [NJ-1:0]   at_target,
   output logic            moving,
   output logic            frame_tick,
   output logic            cmd_err
);
   logic [CNT_W-1:0] r_frame_cnt;
   logic             r_cmd_ready;
   logic             r_frame_tick;
   logic             r_cmd_err;
   logic             r_moving;
   logic             w_wrap;
   logic             w_accept;
   logic             w_joint_ok;
   logic [NJ-1:0]    w_load;
   logic [NJ-1:0]    w_at_nxt;

   assign w_wrap     = (r_frame_cnt == CNT_W'(FRAME_CYCLES - 1));
   assign w_accept   = cmd_valid & r_cmd_ready;
   assign w_joint_ok = (int'(cmd_joint) < NJ);

   for (genvar j = 0; j < NJ; j++) begin : g_joint
      assign w_load[j] = w_accept & w_joint_ok & (cmd_joint == 3'(j));

      servo_joint_ramp #(
         .STEP       (STEP),
         .HOME_ANGLE (HOME_ANGLE),
         .MAX_ANGLE  (MAX_ANGLE)
      ) u_joint (
         .CLK             (CLK),
         .RST_N           (RST_N),
         .i_load          (w_load[j]),
         .i_angle         (cmd_angle),
         .i_step          (w_wrap),
         .o_angle         (angle_bus[8*j +: 8]),
         .o_at_target     (at_target[j]),
         .o_at_target_nxt (w_at_nxt[j])
      );
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_frame_cnt  <= '0;
         r_cmd_ready  <= 1'b0;
         r_frame_tick <= 1'b0;
         r_cmd_err    <= 1'b0;
         r_moving     <= 1'b0;
      end else begin
         r_frame_cnt  <= w_wrap ? '0 : r_frame_cnt + 1'b1;
         r_cmd_ready  <= 1'b1;
         r_frame_tick <= w_wrap;
         r_cmd_err    <= w_accept & ~w_joint_ok;
         r_moving     <= ~&w_at_nxt;
      end
   end

   assign cmd_ready  = r_cmd_ready;
   assign frame_tick = r_frame_tick;
   assign cmd_err    = r_cmd_err;
   assign moving     = r_moving;
endmodule
